// File: rtl/spi_controller.sv
// spi_controller: SPI mode 0 master that sends one 16-bit write frame {1, addr, wdata} per accepted request.
// All outputs are registered from next-state values so they line up with the state register.
module spi_controller #(
    parameter int DIV = 4,
    parameter int CW  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       SCLK,
    output logic       nCS,
    output logic       COPI
);
    if (DIV < 2 || DIV > 255) begin : g_bad_div
        $error("spi_controller: DIV must be in 2..255");
    end
    if (DIV - 1 >= (1 << CW)) begin : g_bad_cw
        $error("spi_controller: CW too narrow for DIV-1");
    end

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, GAP} state_e;

    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [15:0]   sh_q, sh_d;
    logic          busy_q, busy_d, done_q, done_d, sclk_q, sclk_d, ncs_q, ncs_d, copi_q, copi_d;
    logic          last, in_frame;

    assign last = cnt_q == LAST;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = SETUP;
                    sh_d    = {1'b1, addr, wdata};
                    bit_d   = '0;
                end
            end
            SETUP: if (last) begin
                state_d = SHIFT_HI;
                cnt_d   = '0;
            end
            SHIFT_HI: if (last) begin
                state_d = SHIFT_LO;
                cnt_d   = '0;
                // after the 16th high phase bit 0 is held through the last low phase
                if (bit_q != 4'd15) sh_d = {sh_q[14:0], 1'b0};
            end
            SHIFT_LO: if (last) begin
                state_d = (bit_q == 4'd15) ? GAP : SHIFT_HI;
                bit_d   = bit_q + 1'b1;
                cnt_d   = '0;
            end
            GAP: if (last) begin
                state_d = IDLE;
                cnt_d   = '0;
                sh_d    = '0;
            end
            default: state_d = IDLE;
        endcase
        in_frame = state_d inside {SETUP, SHIFT_HI, SHIFT_LO};
        ncs_d    = !in_frame;
        sclk_d   = state_d == SHIFT_HI;
        copi_d   = in_frame & sh_d[15];
        busy_d   = state_d != IDLE;
        done_d   = state_d == GAP && cnt_d == LAST;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            ncs_q   <= 1'b1;
            copi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sclk_q  <= sclk_d;
            ncs_q   <= ncs_d;
            copi_q  <= copi_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign SCLK = sclk_q;
    assign nCS  = ncs_q;
    assign COPI = copi_q;
endmodule
